// File: rtl/controller_pkg.sv
// Shared types and constants for the serial game-controller responder.
package controller_pkg;

   localparam int NUM_BITS_DEF = 8;

   // Serial order: A is shifted out first, RIGHT last.
   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_e;

endpackage

// File: rtl/button_debouncer_m.sv
// Single-bit debouncer: a raw level must hold for DEBOUNCE_CYCLES clocks before it is accepted.
module button_debouncer_m #(
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_B,
   input  logic i_raw,
   output logic o_stable
);

   logic r_stable;

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge rst_B) begin
            if (!rst_B) r_stable <= 1'b0;
            else        r_stable <= i_raw;
         end
      end else begin : g_count
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
         logic [CW-1:0] r_cnt;

         // Counter clears on acceptance, so it can never pass LIMIT or wrap.
         always_ff @(posedge clk or negedge rst_B) begin
            if (!rst_B) begin
               r_stable <= 1'b0;
               r_cnt    <= '0;
            end else if (i_raw == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt == LIMIT) begin
               r_stable <= i_raw;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

   assign o_stable = r_stable;

endmodule

// File: rtl/controller_responder_m.sv
// Controller-side 4021-style responder: debounced buttons are latched and shifted out active-low.
module controller_responder_m
   import controller_pkg::*;
#(
   parameter int   NUM_BITS        = NUM_BITS_DEF,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter logic FILL_BIT_B      = 1'b0
) (
   input  logic                clk,
   input  logic                rst_B,
   input  logic                controller_clk_in,
   input  logic                controller_latch_in,
   input  logic [NUM_BITS-1:0] buttons_in,
   output logic                data_out_B,
   output logic [NUM_BITS-1:0] buttons_stable,
   output logic                poll_done,
   output logic                shift_overrun
);

   localparam int CW = $clog2(NUM_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BITS);

   logic [1:0]          r_clk_s;
   logic [1:0]          r_lat_s;
   logic                r_clk_d;
   logic [NUM_BITS-1:0] r_btn_s1;
   logic [NUM_BITS-1:0] r_btn_s2;

   always_ff @(posedge clk or negedge rst_B) begin
      if (!rst_B) begin
         r_clk_s  <= '0;
         r_lat_s  <= '0;
         r_clk_d  <= 1'b0;
         r_btn_s1 <= '0;
         r_btn_s2 <= '0;
      end else begin
         r_clk_s  <= {r_clk_s[0], controller_clk_in};
         r_lat_s  <= {r_lat_s[0], controller_latch_in};
         r_clk_d  <= r_clk_s[1];
         r_btn_s1 <= buttons_in;
         r_btn_s2 <= r_btn_s1;
      end
   end

   logic w_clk_rise;
   logic w_lat;
   assign w_clk_rise = r_clk_s[1] & ~r_clk_d;
   assign w_lat      = r_lat_s[1];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BITS; gi++) begin : g_db
         button_debouncer_m #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk      (clk),
            .rst_B    (rst_B),
            .i_raw    (r_btn_s2[gi]),
            .o_stable (buttons_stable[gi])
         );
      end
   endgenerate

   state_e              r_state;
   logic [NUM_BITS-1:0] r_shreg;
   logic [CW-1:0]       r_cnt;
   logic                r_poll_done;
   logic                r_overrun;
   logic [CW-1:0]       w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + 1'b1;

   // Latch is checked ahead of the clock edge in every state, so it always wins.
   always_ff @(posedge clk or negedge rst_B) begin
      if (!rst_B) begin
         r_state     <= IDLE;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_poll_done <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_poll_done <= 1'b0;
         r_overrun   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_lat) begin
                  r_state <= LOAD;
                  r_shreg <= buttons_stable;
                  r_cnt   <= '0;
               end else if (w_clk_rise) begin
                  r_overrun <= 1'b1;
               end
            end
            LOAD: begin
               r_shreg <= buttons_stable;
               r_cnt   <= '0;
               if (!w_lat) r_state <= SHIFT;
            end
            SHIFT: begin
               if (w_lat) begin
                  r_state <= LOAD;
                  r_shreg <= buttons_stable;
                  r_cnt   <= '0;
               end else if (w_clk_rise) begin
                  r_shreg <= r_shreg << 1;
                  r_cnt   <= w_cnt_nxt;
                  if (w_cnt_nxt == LAST) begin
                     r_poll_done <= 1'b1;
                     r_state     <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   logic w_data_B;
   always_comb begin
      w_data_B = FILL_BIT_B;
      if (r_state == LOAD || (r_state == SHIFT && r_cnt < LAST))
         w_data_B = ~r_shreg[NUM_BITS-1];
   end

   assign data_out_B    = w_data_B;
   assign poll_done     = r_poll_done;
   assign shift_overrun = r_overrun;

endmodule

// File: tb/tb_controller_responder_m.sv
// Directed bench for controller_responder_m with a serial-bit scoreboard.
module tb_controller_responder_m;

   logic       clk;
   logic       rst_B;
   logic       cclk;
   logic       lat;
   logic [7:0] btn;
   logic       data_out_B;
   logic [7:0] buttons_stable;
   logic       poll_done;
   logic       shift_overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int n_poll  = 0;
   int n_ovr   = 0;
   logic exp_q[$];

   controller_responder_m #(
      .NUM_BITS        (8),
      .DEBOUNCE_CYCLES (4),
      .FILL_BIT_B      (1'b0)
   ) dut (
      .clk                 (clk),
      .rst_B               (rst_B),
      .controller_clk_in   (cclk),
      .controller_latch_in (lat),
      .buttons_in          (btn),
      .data_out_B          (data_out_B),
      .buttons_stable      (buttons_stable),
      .poll_done           (poll_done),
      .shift_overrun       (shift_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (poll_done)     n_poll++;
      if (shift_overrun) n_ovr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      cclk = 1'b1; cyc(4);
      cclk = 1'b0; cyc(4);
   endtask

   // Expected serial stream is queued at the moment the latch is driven.
   task automatic do_latch(input logic [7:0] b);
      exp_q.delete();
      for (int i = 7; i >= 0; i--) exp_q.push_back(~b[i]);
      lat = 1'b1; cyc(4);
      lat = 1'b0; cyc(4);
   endtask

   task automatic sample(input string tag);
      logic e;
      e = 1'b0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check(tag, {31'd0, data_out_B}, {31'd0, e});
   endtask

   task automatic full_poll(input string tag, input logic [7:0] b);
      int p0;
      p0 = n_poll;
      do_latch(b);
      sample({tag, "_b0"});
      for (int i = 1; i < 8; i++) begin
         pulse();
         sample($sformatf("%s_b%0d", tag, i));
      end
      pulse();
      check({tag, "_fill"}, {31'd0, data_out_B}, 32'd0);
      check({tag, "_done"}, n_poll, p0 + 1);
   endtask

   initial begin
      int p0;
      int o0;
      rst_B = 1'b0; lat = 1'b0; cclk = 1'b0; btn = 8'h00;
      cyc(3);
      check("rst_data",   {31'd0, data_out_B}, 32'd0);
      check("rst_done",   {31'd0, poll_done}, 32'd0);
      check("rst_ovr",    {31'd0, shift_overrun}, 32'd0);
      check("rst_stable", {24'd0, buttons_stable}, 32'h00);
      rst_B = 1'b1; cyc(2);

      // Debounce latency: 2 sync + 4 count + 1 accept.
      btn = 8'hA5;
      cyc(6);
      check("db_early", {24'd0, buttons_stable}, 32'h00);
      cyc(1);
      check("db_a5", {24'd0, buttons_stable}, 32'hA5);
      cyc(3);

      full_poll("a5", 8'hA5);

      for (int i = 0; i < 20; i++) begin
         btn[7] = ((i / 2) % 2) == 1;
         cyc(1);
         if (i % 4 == 3) check($sformatf("bounce_%0d", i), {31'd0, buttons_stable[7]}, 32'd1);
      end
      btn[7] = 1'b1;
      cyc(6);
      check("bounce_end", {24'd0, buttons_stable}, 32'hA5);

      btn = 8'hFF;
      cyc(10);
      check("db_ff", {24'd0, buttons_stable}, 32'hFF);
      p0 = n_poll;
      do_latch(8'hFF);
      sample("part_b0");
      for (int i = 1; i <= 3; i++) begin
         pulse();
         sample($sformatf("part_b%0d", i));
      end
      do_latch(8'hFF);
      check("relatch_nodone", n_poll, p0);
      sample("relatch_b0");
      for (int i = 1; i < 8; i++) begin
         pulse();
         sample($sformatf("relatch_b%0d", i));
      end
      pulse();
      check("relatch_fill", {31'd0, data_out_B}, 32'd0);
      check("relatch_done", n_poll, p0 + 1);

      o0 = n_ovr;
      p0 = n_poll;
      pulse();
      check("ovr_pulse", n_ovr, o0 + 1);
      check("ovr_data",  {31'd0, data_out_B}, 32'd0);
      check("ovr_nodone", n_poll, p0);

      btn = 8'hA5;
      cyc(10);
      p0 = n_poll;
      do_latch(8'hA5);
      sample("mid_b0");
      for (int i = 1; i <= 3; i++) begin
         pulse();
         sample($sformatf("mid_b%0d", i));
      end
      rst_B = 1'b0;
      #1;
      check("mid_rst_data",   {31'd0, data_out_B}, 32'd0);
      check("mid_rst_stable", {24'd0, buttons_stable}, 32'h00);
      cyc(2);
      rst_B = 1'b1;
      check("mid_rst_nodone", n_poll, p0);
      cyc(10);
      check("post_rst_db", {24'd0, buttons_stable}, 32'hA5);
      full_poll("post", 8'hA5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
